// File: rtl/game_pkg.sv
// Shared game-wide constants and types for the sprite pipeline.
package game_pkg;

  localparam int SCREEN_CORDW = 16;
  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int MAX_OBJ      = 32;

  typedef logic [SCREEN_CORDW-1:0] coord_t;

endpackage : game_pkg

// File: rtl/lowest_index_encoder.sv
// Combinational priority encoder: reports the lowest set bit of vec.
module lowest_index_encoder #(
  parameter  int N     = 8,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so that the lowest set index is written last and wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule : lowest_index_encoder

// File: rtl/sprite_collision_unit.sv
// Per-frame collision detector between the player sprite and N_OBJ obstacles.
// Accumulates overlaps over a frame and publishes them on the frame pulse.
//
// Handshake: result_valid is a one-cycle strobe with no ready/back-pressure;
// published outputs are stable from the strobe cycle until the next strobe,
// except sticky_mask, which may also change on a clear.
module sprite_collision_unit
  import game_pkg::*;
#(
  parameter  int N_OBJ    = 8,
  parameter  int CORDW    = SCREEN_CORDW,
  parameter  int STREAK_W = 8,
  localparam int IDX_W    = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic                clk_pix,
  input  logic                rst,
  input  logic                en,
  input  logic                frame,
  input  logic                de,
  input  logic [CORDW-1:0]    screen_x,
  input  logic [CORDW-1:0]    screen_y,
  input  logic                player_drawing,
  input  logic [N_OBJ-1:0]    obj_drawing,
  input  logic [N_OBJ-1:0]    obj_mask,
  input  logic                clear,
  output logic                result_valid,
  output logic [N_OBJ-1:0]    hit_mask,
  output logic                hit_any,
  output logic [IDX_W-1:0]    first_idx,
  output logic [CORDW-1:0]    first_x,
  output logic [CORDW-1:0]    first_y,
  output logic [N_OBJ-1:0]    sticky_mask,
  output logic [STREAK_W-1:0] streak
);

  logic [N_OBJ-1:0]    ov;
  logic [IDX_W-1:0]    ov_idx;
  logic                ov_valid;

  logic [N_OBJ-1:0]    acc_q, acc_d;
  logic                first_seen_q, first_seen_d;
  logic [IDX_W-1:0]    sh_idx_q, sh_idx_d;
  logic [CORDW-1:0]    sh_x_q, sh_x_d;
  logic [CORDW-1:0]    sh_y_q, sh_y_d;

  logic                result_valid_q, result_valid_d;
  logic [N_OBJ-1:0]    hit_mask_q, hit_mask_d;
  logic                hit_any_q, hit_any_d;
  logic [IDX_W-1:0]    first_idx_q, first_idx_d;
  logic [CORDW-1:0]    first_x_q, first_x_d;
  logic [CORDW-1:0]    first_y_q, first_y_d;
  logic [N_OBJ-1:0]    sticky_q, sticky_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  // Overlaps of the current pixel; used directly, never registered first.
  assign ov = {N_OBJ{en & de & player_drawing}} & obj_drawing & obj_mask;

  lowest_index_encoder #(.N(N_OBJ)) u_first_enc (
    .vec   (ov),
    .idx   (ov_idx),
    .valid (ov_valid)
  );

  // Next-state: accumulate within a frame, publish and restart on the frame pulse.
  always_comb begin
    acc_d          = acc_q;
    first_seen_d   = first_seen_q;
    sh_idx_d       = sh_idx_q;
    sh_x_d         = sh_x_q;
    sh_y_d         = sh_y_q;
    result_valid_d = 1'b0;
    hit_mask_d     = hit_mask_q;
    hit_any_d      = hit_any_q;
    first_idx_d    = first_idx_q;
    first_x_d      = first_x_q;
    first_y_d      = first_y_q;
    sticky_d       = clear ? '0 : sticky_q;
    streak_d       = streak_q;

    if (frame) begin
      result_valid_d = 1'b1;
      hit_mask_d     = acc_q;
      hit_any_d      = |acc_q;
      first_idx_d    = first_seen_q ? sh_idx_q : '0;
      first_x_d      = first_seen_q ? sh_x_q   : '0;
      first_y_d      = first_seen_q ? sh_y_q   : '0;
      sticky_d       = sticky_d | acc_q;
      if (|acc_q)
        streak_d = (streak_q == '1) ? streak_q : streak_q + STREAK_W'(1);
      else
        streak_d = '0;
      // The frame cycle's own overlap opens the new frame.
      acc_d        = ov;
      first_seen_d = ov_valid;
      sh_idx_d     = ov_valid ? ov_idx   : '0;
      sh_x_d       = ov_valid ? screen_x : '0;
      sh_y_d       = ov_valid ? screen_y : '0;
    end else begin
      acc_d = acc_q | ov;
      if (!first_seen_q && ov_valid) begin
        first_seen_d = 1'b1;
        sh_idx_d     = ov_idx;
        sh_x_d       = screen_x;
        sh_y_d       = screen_y;
      end
    end
  end

  // State registers; reset wins over frame and clear.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      acc_q          <= '0;
      first_seen_q   <= 1'b0;
      sh_idx_q       <= '0;
      sh_x_q         <= '0;
      sh_y_q         <= '0;
      result_valid_q <= 1'b0;
      hit_mask_q     <= '0;
      hit_any_q      <= 1'b0;
      first_idx_q    <= '0;
      first_x_q      <= '0;
      first_y_q      <= '0;
      sticky_q       <= '0;
      streak_q       <= '0;
    end else begin
      acc_q          <= acc_d;
      first_seen_q   <= first_seen_d;
      sh_idx_q       <= sh_idx_d;
      sh_x_q         <= sh_x_d;
      sh_y_q         <= sh_y_d;
      result_valid_q <= result_valid_d;
      hit_mask_q     <= hit_mask_d;
      hit_any_q      <= hit_any_d;
      first_idx_q    <= first_idx_d;
      first_x_q      <= first_x_d;
      first_y_q      <= first_y_d;
      sticky_q       <= sticky_d;
      streak_q       <= streak_d;
    end
  end

  assign result_valid = result_valid_q;
  assign hit_mask     = hit_mask_q;
  assign hit_any      = hit_any_q;
  assign first_idx    = first_idx_q;
  assign first_x      = first_x_q;
  assign first_y      = first_y_q;
  assign sticky_mask  = sticky_q;
  assign streak       = streak_q;

endmodule : sprite_collision_unit

// File: tb/tb_sprite_collision_unit.sv
// Directed, table-driven bench for sprite_collision_unit.
module tb_sprite_collision_unit;

  typedef struct {
    logic        rst, en, de, pd, fr, clr;
    logic [7:0]  od, om;
    logic [15:0] x, y;
    logic        chk, rv;
    logic [7:0]  hm;
    logic [2:0]  fi;
    logic [15:0] fx, fy;
    logic [7:0]  sm, st;
  } vec_t;

  // ---------------- clock / reset / signals ----------------
  logic        clk_pix = 1'b0;
  logic        rst = 1'b1, en = 1'b0, frame = 1'b0, de = 1'b0, player_drawing = 1'b0, clear = 1'b0;
  logic [15:0] screen_x = '0, screen_y = '0;
  logic [7:0]  obj_drawing = '0, obj_mask = '0;

  logic        result_valid, hit_any;
  logic [7:0]  hit_mask, sticky_mask, streak;
  logic [2:0]  first_idx;
  logic [15:0] first_x, first_y;

  logic        s2_result_valid, s2_hit_any;
  logic [7:0]  s2_hit_mask, s2_sticky_mask;
  logic [1:0]  s2_streak;
  logic [2:0]  s2_first_idx;
  logic [15:0] s2_first_x, s2_first_y;

  int n_pass  = 0;
  int n_total = 0;

  always #20 clk_pix = ~clk_pix;

  sprite_collision_unit dut (
    .clk_pix(clk_pix), .rst(rst), .en(en), .frame(frame), .de(de),
    .screen_x(screen_x), .screen_y(screen_y), .player_drawing(player_drawing),
    .obj_drawing(obj_drawing), .obj_mask(obj_mask), .clear(clear),
    .result_valid(result_valid), .hit_mask(hit_mask), .hit_any(hit_any),
    .first_idx(first_idx), .first_x(first_x), .first_y(first_y),
    .sticky_mask(sticky_mask), .streak(streak)
  );

  sprite_collision_unit #(.STREAK_W(2)) dut_s2 (
    .clk_pix(clk_pix), .rst(rst), .en(en), .frame(frame), .de(de),
    .screen_x(screen_x), .screen_y(screen_y), .player_drawing(player_drawing),
    .obj_drawing(obj_drawing), .obj_mask(obj_mask), .clear(clear),
    .result_valid(s2_result_valid), .hit_mask(s2_hit_mask), .hit_any(s2_hit_any),
    .first_idx(s2_first_idx), .first_x(s2_first_x), .first_y(s2_first_y),
    .sticky_mask(s2_sticky_mask), .streak(s2_streak)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  function automatic vec_t vin(logic r, logic e, logic d, logic p, logic f, logic c,
                               logic [7:0] od, logic [7:0] om, logic [15:0] x, logic [15:0] y);
    vec_t v;
    v.rst = r; v.en = e; v.de = d; v.pd = p; v.fr = f; v.clr = c;
    v.od = od; v.om = om; v.x = x; v.y = y;
    v.chk = 1'b0; v.rv = 1'b0; v.hm = '0; v.fi = '0; v.fx = '0; v.fy = '0; v.sm = '0; v.st = '0;
    return v;
  endfunction

  function automatic vec_t vexp(vec_t vi, logic rv, logic [7:0] hm, logic [2:0] fi,
                                logic [15:0] fx, logic [15:0] fy, logic [7:0] sm, logic [7:0] st);
    vec_t v;
    v = vi;
    v.chk = 1'b1; v.rv = rv; v.hm = hm; v.fi = fi; v.fx = fx; v.fy = fy; v.sm = sm; v.st = st;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; en = v.en; de = v.de; player_drawing = v.pd; frame = v.fr; clear = v.clr;
    obj_drawing = v.od; obj_mask = v.om; screen_x = v.x; screen_y = v.y;
    @(posedge clk_pix);
    #1;
  endtask

  task automatic check_row(input int r, input vec_t v);
    string t;
    t = $sformatf("row%0d", r);
    check({t, ".result_valid"}, 32'(result_valid), 32'(v.rv));
    check({t, ".hit_mask"},     32'(hit_mask),     32'(v.hm));
    check({t, ".hit_any"},      32'(hit_any),      32'(v.hm != 8'h00));
    check({t, ".first_idx"},    32'(first_idx),    32'(v.fi));
    check({t, ".first_x"},      32'(first_x),      32'(v.fx));
    check({t, ".first_y"},      32'(first_y),      32'(v.fy));
    check({t, ".sticky_mask"},  32'(sticky_mask),  32'(v.sm));
    check({t, ".streak"},       32'(streak),       32'(v.st));
  endtask

  vec_t tbl[$];

  // ---------------- stimulus ----------------
  initial begin
    //                 rst en de pd fr cl  od     om     x    y
    // reset and idle
    tbl.push_back(vexp(vin(1, 0, 0, 0, 0, 0, 8'h00, 8'hFF, 0, 0),     0, 8'h00, 0, 0, 0, 8'h00, 0));
    tbl.push_back(vexp(vin(0, 1, 1, 0, 0, 0, 8'h00, 8'hFF, 0, 0),     0, 8'h00, 0, 0, 0, 8'h00, 0));
    // single hit at (100,300) on bit 2
    tbl.push_back(vexp(vin(0, 1, 1, 1, 0, 0, 8'h04, 8'hFF, 100, 300), 0, 8'h00, 0, 0, 0, 8'h00, 0));
    tbl.push_back(vexp(vin(0, 1, 1, 0, 1, 0, 8'h00, 8'hFF, 0, 0),     1, 8'h04, 2, 100, 300, 8'h04, 1));
    tbl.push_back(vexp(vin(0, 1, 1, 0, 0, 0, 8'h00, 8'hFF, 0, 0),     0, 8'h04, 2, 100, 300, 8'h04, 1));
    // priority: tie on bits 4/5 first, later bit 0
    tbl.push_back(vin(0, 1, 1, 1, 0, 0, 8'h30, 8'hFF, 50, 10));
    tbl.push_back(vin(0, 1, 1, 1, 0, 0, 8'h01, 8'hFF, 20, 40));
    tbl.push_back(vin(0, 1, 1, 0, 0, 0, 8'h00, 8'hFF, 0, 0));
    tbl.push_back(vexp(vin(0, 1, 1, 0, 1, 0, 8'h00, 8'hFF, 0, 0),     1, 8'h31, 4, 50, 10, 8'h35, 2));
    // obj_mask blocks bit 2
    tbl.push_back(vin(0, 1, 1, 1, 0, 0, 8'h04, 8'hFB, 7, 7));
    tbl.push_back(vexp(vin(0, 1, 1, 0, 1, 0, 8'h00, 8'hFF, 0, 0),     1, 8'h00, 0, 0, 0, 8'h35, 0));
    // en low blocks
    tbl.push_back(vin(0, 0, 1, 1, 0, 0, 8'h04, 8'hFF, 7, 7));
    tbl.push_back(vexp(vin(0, 1, 1, 0, 1, 0, 8'h00, 8'hFF, 0, 0),     1, 8'h00, 0, 0, 0, 8'h35, 0));
    // de low blocks
    tbl.push_back(vin(0, 1, 0, 1, 0, 0, 8'h04, 8'hFF, 7, 7));
    tbl.push_back(vexp(vin(0, 1, 1, 0, 1, 0, 8'h00, 8'hFF, 0, 0),     1, 8'h00, 0, 0, 0, 8'h35, 0));
    // clear alone touches only sticky_mask
    tbl.push_back(vexp(vin(0, 1, 1, 0, 0, 1, 8'h00, 8'hFF, 0, 0),     0, 8'h00, 0, 0, 0, 8'h00, 0));
    // frame A: bit 1, frame B: bit 6
    tbl.push_back(vin(0, 1, 1, 1, 0, 0, 8'h02, 8'hFF, 1, 2));
    tbl.push_back(vexp(vin(0, 1, 1, 0, 1, 0, 8'h00, 8'hFF, 0, 0),     1, 8'h02, 1, 1, 2, 8'h02, 1));
    tbl.push_back(vin(0, 1, 1, 1, 0, 0, 8'h40, 8'hFF, 3, 4));
    tbl.push_back(vexp(vin(0, 1, 1, 0, 1, 0, 8'h00, 8'hFF, 0, 0),     1, 8'h40, 6, 3, 4, 8'h42, 2));
    tbl.push_back(vexp(vin(0, 1, 1, 0, 0, 1, 8'h00, 8'hFF, 0, 0),     0, 8'h40, 6, 3, 4, 8'h00, 2));
    // clear together with a frame whose acc is 8'h08
    tbl.push_back(vin(0, 1, 1, 1, 0, 0, 8'h08, 8'hFF, 5, 6));
    tbl.push_back(vexp(vin(0, 1, 1, 0, 1, 1, 8'h00, 8'hFF, 0, 0),     1, 8'h08, 3, 5, 6, 8'h08, 3));
    // overlap in the frame cycle belongs to the next frame; back-to-back frames
    tbl.push_back(vexp(vin(0, 1, 1, 1, 1, 0, 8'h01, 8'hFF, 9, 9),     1, 8'h00, 0, 0, 0, 8'h08, 0));
    tbl.push_back(vexp(vin(0, 1, 1, 0, 1, 0, 8'h00, 8'hFF, 0, 0),     1, 8'h01, 0, 9, 9, 8'h09, 1));
    tbl.push_back(vexp(vin(0, 1, 1, 0, 1, 0, 8'h00, 8'hFF, 0, 0),     1, 8'h00, 0, 0, 0, 8'h09, 0));
    // overlap on bit 3 in a frame cycle shows up only after the following frame
    tbl.push_back(vexp(vin(0, 1, 1, 1, 1, 0, 8'h08, 8'hFF, 12, 13),   1, 8'h00, 0, 0, 0, 8'h09, 0));
    tbl.push_back(vexp(vin(0, 1, 1, 0, 1, 0, 8'h00, 8'hFF, 0, 0),     1, 8'h08, 3, 12, 13, 8'h09, 1));
    // reset mid-frame (with frame and clear asserted) discards the partial frame
    tbl.push_back(vin(0, 1, 1, 1, 0, 0, 8'h10, 8'hFF, 11, 12));
    tbl.push_back(vexp(vin(1, 1, 1, 0, 1, 1, 8'h00, 8'hFF, 0, 0),     0, 8'h00, 0, 0, 0, 8'h00, 0));
    tbl.push_back(vin(0, 1, 1, 0, 0, 0, 8'h00, 8'hFF, 0, 0));
    tbl.push_back(vexp(vin(0, 1, 1, 0, 1, 0, 8'h00, 8'hFF, 0, 0),     1, 8'h00, 0, 0, 0, 8'h00, 0));
    tbl.push_back(vexp(vin(0, 1, 1, 0, 0, 0, 8'h00, 8'hFF, 0, 0),     0, 8'h00, 0, 0, 0, 8'h00, 0));

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r]);
      if (tbl[r].chk) check_row(r, tbl[r]);
    end

    // Streak saturation: five colliding frames, then one clean frame.
    // The 2-bit instance saturates at 3; the 8-bit instance keeps counting.
    for (int f = 1; f <= 5; f++) begin
      drive(vin(0, 1, 1, 1, 0, 0, 8'h80, 8'hFF, 16'(f), 16'(f)));
      drive(vin(0, 1, 1, 0, 1, 0, 8'h00, 8'hFF, 0, 0));
      check($sformatf("sat%0d.s2_streak", f), 32'(s2_streak), (f < 3) ? f : 3);
      check($sformatf("sat%0d.streak", f),    32'(streak),    f);
      check($sformatf("sat%0d.s2_first_x", f), 32'(s2_first_x), f);
    end
    drive(vin(0, 1, 1, 0, 0, 0, 8'h00, 8'hFF, 0, 0));
    check("sat.rv_pulse_low", 32'(s2_result_valid), 0);
    drive(vin(0, 1, 1, 0, 1, 0, 8'h00, 8'hFF, 0, 0));
    check("sat_clean.s2_streak", 32'(s2_streak), 0);
    check("sat_clean.streak",    32'(streak),    0);
    check("sat_clean.s2_sticky", 32'(s2_sticky_mask), 32'h80);
    check("sat_clean.s2_hit_any", 32'(s2_hit_any), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_sprite_collision_unit
